// File: rtl/pipelined_segmented_adder_pkg.sv
// Shared elaboration helpers for the segmented adder: stage count and
// the legality rule that WIDTH must split into whole SEG_W-bit segments.
package pipelined_segmented_adder_pkg;

    function automatic int calcNseg(input int width, input int segW);
        return width / segW;
    endfunction

    function automatic bit segLegal(input int width, input int segW);
        return (segW > 0) && (width >= segW) && ((width % segW) == 0);
    endfunction

endpackage

// File: rtl/pipelined_segmented_adder_if.sv
// Operand/result bundle of the segmented adder; master drives operands
// and the pipeline enable, slave (the adder) returns the tagged result.
interface pipelined_segmented_adder_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic             valid_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             valid_out;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output en, valid_in, a, b, cin, sub,
        input  valid_out, sum, cout, ovf
    );

    modport slave (
        input  en, valid_in, a, b, cin, sub,
        output valid_out, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_segmented_adder_segment_adder.sv
// Combinational SEG_W-bit ripple chain built from the full-adder cell;
// c_msb exposes the carry into the top bit for signed-overflow detection.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module segment_adder #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    // Per-bit carry nets live in their own generate scopes so the chain is not one looping vector.
    for (genvar i = 0; i < SEG_W; i++) begin : g_bit
        logic ci;
        logic co;
        if (i == 0) begin : g_first
            assign ci = cin;
        end else begin : g_next
            assign ci = g_bit[i-1].co;
        end
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (ci),
            .sum  (sum[i]),
            .cout (co)
        );
    end

    assign cout  = g_bit[SEG_W-1].co;
    assign c_msb = g_bit[SEG_W-1].ci;
endmodule

// File: rtl/pipelined_segmented_adder.sv
// Pipelined add/subtract: one SEG_W-bit segment resolved per stage, carry registered
// between stages, operands skewed in and sums deskewed out so a result emerges whole.
module pipelined_segmented_adder
    import pipelined_segmented_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input logic clk,
    input logic rst,
    pipelined_segmented_adder_if.slave bus
);
    localparam int NSEG = calcNseg(WIDTH, SEG_W);

    if (!segLegal(WIDTH, SEG_W)) begin : g_bad_width
        $error("pipelined_segmented_adder: WIDTH must be a positive multiple of SEG_W");
    end

    logic [WIDTH-1:0] bEff;
    logic             c0;
    logic [NSEG-1:0]  carryOut;
    logic [NSEG-1:0]  valid_q;
    logic [WIDTH-1:0] sumOut;
    logic             lastMsb;

    assign bEff = bus.b ^ {WIDTH{bus.sub}};
    assign c0   = bus.sub | bus.cin;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        localparam int DEPTH = NSEG - 1 - k;
        logic [SEG_W-1:0] aStage;
        logic [SEG_W-1:0] bStage;
        logic             carryIn;
        logic [SEG_W-1:0] segSum_d;
        logic             segCout_d;
        logic             segMsb_d;
        logic [SEG_W-1:0] segSum_q;
        logic             segCarry_q;

        if (k == 0) begin : g_noskew
            assign aStage  = bus.a[SEG_W-1:0];
            assign bStage  = bEff[SEG_W-1:0];
            assign carryIn = c0;
        end else begin : g_skew
            // Segment k waits k cycles so it meets the carry rippling up from stage k-1.
            logic [SEG_W-1:0] aSkew_q [k];
            logic [SEG_W-1:0] bSkew_q [k];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < k; j++) begin
                        aSkew_q[j] <= '0;
                        bSkew_q[j] <= '0;
                    end
                end else if (bus.en) begin
                    aSkew_q[0] <= bus.a[k*SEG_W +: SEG_W];
                    bSkew_q[0] <= bEff[k*SEG_W +: SEG_W];
                    for (int j = 1; j < k; j++) begin
                        aSkew_q[j] <= aSkew_q[j-1];
                        bSkew_q[j] <= bSkew_q[j-1];
                    end
                end
            end
            assign aStage  = aSkew_q[k-1];
            assign bStage  = bSkew_q[k-1];
            assign carryIn = carryOut[k-1];
        end

        segment_adder #(.SEG_W(SEG_W)) u_add (
            .a     (aStage),
            .b     (bStage),
            .cin   (carryIn),
            .sum   (segSum_d),
            .cout  (segCout_d),
            .c_msb (segMsb_d)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                segSum_q   <= '0;
                segCarry_q <= 1'b0;
            end else if (bus.en) begin
                segSum_q   <= segSum_d;
                segCarry_q <= segCout_d;
            end
        end
        assign carryOut[k] = segCarry_q;

        if (k == NSEG - 1) begin : g_last
            // Carry into the MSB travels with the final stage so ovf lines up with cout.
            logic msbCarry_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    msbCarry_q <= 1'b0;
                end else if (bus.en) begin
                    msbCarry_q <= segMsb_d;
                end
            end
            assign lastMsb = msbCarry_q;
        end else begin : g_mid
            logic unusedMsb;
            assign unusedMsb = segMsb_d;
        end

        if (DEPTH == 0) begin : g_nodeskew
            assign sumOut[k*SEG_W +: SEG_W] = segSum_q;
        end else begin : g_deskew
            logic [SEG_W-1:0] dly_q [DEPTH];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        dly_q[j] <= '0;
                    end
                end else if (bus.en) begin
                    dly_q[0] <= segSum_q;
                    for (int j = 1; j < DEPTH; j++) begin
                        dly_q[j] <= dly_q[j-1];
                    end
                end
            end
            assign sumOut[k*SEG_W +: SEG_W] = dly_q[DEPTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (bus.en) begin
            valid_q[0] <= bus.valid_in;
            for (int j = 1; j < NSEG; j++) begin
                valid_q[j] <= valid_q[j-1];
            end
        end
    end

    assign bus.valid_out = valid_q[NSEG-1];
    assign bus.sum       = sumOut;
    assign bus.cout      = carryOut[NSEG-1];
    assign bus.ovf       = lastMsb ^ carryOut[NSEG-1];
endmodule
